// File: rtl/dac_update_scheduler.sv
// ---------------------------------------------------------------------------
// dac_update_scheduler
//
// Purpose:
//   Lets NUM_CH logical DAC channels share one DAC write engine. The host
//   writes per-channel shadow values at any rate. Each write marks its
//   channel dirty. Dirty channels are served round-robin, one engine transfer
//   at a time, and only the latest shadow value of a channel is ever sent.
//
// Optional feature (macro DAC_SCHED_REFRESH_EN):
//   When defined, a counter runs while the block is idle. After
//   REFRESH_CYCLES idle cycles every channel is marked dirty again, so the
//   DAC outputs are re-asserted after a brown-out. When undefined, channels
//   are written only after shadow writes and REFRESH_CYCLES is unused.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   upd_we        shadow write strobe (always accepted)
//   upd_ch        channel written by upd_we (values >= NUM_CH are ignored)
//   upd_value     new code for upd_ch
//   dac_enable    request to the DAC engine, held until dac_busy rises
//   dac_ch        channel of the current transfer
//   dac_value     code of the current transfer
//   dac_busy      engine busy; low only when the engine can accept
//   pending       dirty bit per channel
//   idle          registered; high in IDLE with no pending channel
//   timeout_err   one-cycle pulse when an issue is abandoned
//   dbg_state     current FSM state (IDLE=0, ISSUE=1, WAIT=2, GAP=3)
//
// Engine handshake (valid/ready style):
//   dac_enable acts as valid and dac_busy rising acts as accept. While
//   dac_enable is high, dac_ch and dac_value stay stable. A transfer is
//   accepted on the first cycle dac_busy is seen high, and dac_enable drops
//   on the next cycle. A new transfer is only offered after dac_busy has been
//   low for the enforced gap.
// ---------------------------------------------------------------------------
module dac_update_scheduler #(
    parameter int NUM_CH         = 2,
    parameter int CH_W           = 1,
    parameter int VAL_W          = 12,
    parameter int ACCEPT_TIMEOUT = 1024,
    parameter int GAP_CYCLES     = 16,
    parameter int REFRESH_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_we,
    input  logic [CH_W-1:0]   upd_ch,
    input  logic [VAL_W-1:0]  upd_value,
    output logic              dac_enable,
    output logic [CH_W-1:0]   dac_ch,
    output logic [VAL_W-1:0]  dac_value,
    input  logic              dac_busy,
    output logic [NUM_CH-1:0] pending,
    output logic              idle,
    output logic              timeout_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    // One counter serves both the accept timeout (ISSUE) and the gap (GAP),
    // so it is sized for the larger of the two.
    localparam int CNT_MAX = (ACCEPT_TIMEOUT > GAP_CYCLES) ? ACCEPT_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Parameter sanity check at elaboration time.
    if (NUM_CH < 2 || NUM_CH > 8 || (1 << CH_W) < NUM_CH ||
        ACCEPT_TIMEOUT < 1 || GAP_CYCLES < 1 || REFRESH_CYCLES < 2) begin : g_bad_params
        $error("dac_update_scheduler: illegal parameter combination");
    end

    state_e             state_q, state_d;
    logic [NUM_CH-1:0]  pending_q, pending_d;
    logic [VAL_W-1:0]   shadow_q [NUM_CH];
    logic [VAL_W-1:0]   shadow_d [NUM_CH];
    logic [CH_W-1:0]    rr_q, rr_d;
    logic               dac_enable_q, dac_enable_d;
    logic [CH_W-1:0]    dac_ch_q, dac_ch_d;
    logic [VAL_W-1:0]   dac_value_q, dac_value_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               idle_q, idle_d;
    logic               timeout_err_q, timeout_err_d;

`ifdef DAC_SCHED_REFRESH_EN
    localparam int RCNT_W = $clog2(REFRESH_CYCLES);
    logic [RCNT_W-1:0]  refresh_cnt_q, refresh_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Round-robin selection: lowest pending index at or above rr_q, else
    // the lowest pending index overall (the wrap-around case). Descending
    // loops let the lowest match overwrite higher ones.
    // ------------------------------------------------------------------
    logic              hi_found, lo_found;
    logic [CH_W-1:0]   hi_sel, lo_sel, sel;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lo_found = 1'b1;
                lo_sel   = CH_W'(i);
                if (i >= int'(rr_q)) begin
                    hi_found = 1'b1;
                    hi_sel   = CH_W'(i);
                end
            end
        end
        sel = hi_found ? hi_sel : lo_sel;
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        shadow_d      = shadow_q;
        rr_d          = rr_q;
        dac_enable_d  = dac_enable_q;
        dac_ch_d      = dac_ch_q;
        dac_value_d   = dac_value_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`ifdef DAC_SCHED_REFRESH_EN
        refresh_cnt_d = refresh_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (lo_found && !dac_busy) begin
                    // The latch reads shadow_q, so a same-cycle write to
                    // this channel is sent on the following transfer.
                    dac_ch_d       = sel;
                    dac_value_d    = shadow_q[sel];
                    pending_d[sel] = 1'b0;
                    rr_d           = (int'(sel) == NUM_CH - 1) ? '0 : sel + CH_W'(1);
                    dac_enable_d   = 1'b1;
                    cnt_d          = '0;
                    state_d        = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (dac_busy) begin
                    dac_enable_d = 1'b0;
                    state_d      = S_WAIT;
                end else if (cnt_q == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
                    // Abandon the attempt. The channel is re-marked dirty
                    // so the latest shadow value is retried after the gap.
                    dac_enable_d        = 1'b0;
                    timeout_err_d       = 1'b1;
                    pending_d[dac_ch_q] = 1'b1;
                    cnt_d               = CNT_W'(GAP_CYCLES);
                    state_d             = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT: begin
                if (!dac_busy) begin
                    cnt_d   = CNT_W'(GAP_CYCLES);
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                // The engine may still raise busy during the gap (e.g. after
                // a timeout). Leave only once the count is spent and it is free.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!dac_busy) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DAC_SCHED_REFRESH_EN
        if (upd_we || !idle_q) begin
            refresh_cnt_d = '0;
        end else if (refresh_cnt_q == RCNT_W'(REFRESH_CYCLES - 1)) begin
            refresh_cnt_d = '0;
            pending_d     = '1;
        end else begin
            refresh_cnt_d = refresh_cnt_q + RCNT_W'(1);
        end
`endif

        // The shadow write comes last so that its set wins over a clear
        // made by the latch in the same cycle.
        if (upd_we && (int'(upd_ch) < NUM_CH)) begin
            shadow_d[upd_ch]  = upd_value;
            pending_d[upd_ch] = 1'b1;
        end

        idle_d = (state_d == S_IDLE) && (pending_d == '0);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            rr_q          <= '0;
            dac_enable_q  <= 1'b0;
            dac_ch_q      <= '0;
            dac_value_q   <= '0;
            cnt_q         <= '0;
            idle_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
`ifdef DAC_SCHED_REFRESH_EN
            refresh_cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            rr_q          <= rr_d;
            dac_enable_q  <= dac_enable_d;
            dac_ch_q      <= dac_ch_d;
            dac_value_q   <= dac_value_d;
            cnt_q         <= cnt_d;
            idle_q        <= idle_d;
            timeout_err_q <= timeout_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
`ifdef DAC_SCHED_REFRESH_EN
            refresh_cnt_q <= refresh_cnt_d;
`endif
        end
    end

    assign dac_enable  = dac_enable_q;
    assign dac_ch      = dac_ch_q;
    assign dac_value   = dac_value_q;
    assign pending     = pending_q;
    assign idle        = idle_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
module tb_dac_update_scheduler;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int VAL_W  = 12;
  localparam int TO     = 20;
  localparam int GAP    = 4;
  localparam int REF    = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              upd_we = 1'b0;
  logic [CH_W-1:0]   upd_ch = '0;
  logic [VAL_W-1:0]  upd_value = '0;
  logic              dac_enable;
  logic [CH_W-1:0]   dac_ch;
  logic [VAL_W-1:0]  dac_value;
  logic              dac_busy = 1'b0;
  logic [NUM_CH-1:0] pending;
  logic              idle;
  logic              timeout_err;
  logic [1:0]        dbg_state;

  dac_update_scheduler #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .VAL_W(VAL_W),
    .ACCEPT_TIMEOUT(TO), .GAP_CYCLES(GAP), .REFRESH_CYCLES(REF)
  ) dut (
    .clk(clk), .rst(rst), .upd_we(upd_we), .upd_ch(upd_ch), .upd_value(upd_value),
    .dac_enable(dac_enable), .dac_ch(dac_ch), .dac_value(dac_value), .dac_busy(dac_busy),
    .pending(pending), .idle(idle), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Transfer-level view: the bus is either free, requesting (m_en),
  // owned by the engine (m_inflight) or cooling down (m_cool >= 0).
  logic [CH_W+VAL_W-1:0] exp_q[$];
  logic [CH_W+VAL_W-1:0] got_log[$];
  logic [VAL_W-1:0]  m_shadow [NUM_CH];
  logic [NUM_CH-1:0] m_pend = '0;
  int m_rr = 0, m_ch = 0, m_held = 0, m_cool = -1, m_rcnt = 0;
  logic [VAL_W-1:0] m_val = '0;
  bit m_en = 0, m_inflight = 0, m_idle = 1, m_to = 0;

  task automatic model_step();
    int c;
    m_to = 0;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) m_shadow[i] = '0;
      m_pend = '0; m_rr = 0; m_ch = 0; m_val = '0; m_held = 0; m_cool = -1; m_rcnt = 0;
      m_en = 0; m_inflight = 0; m_idle = 1;
      exp_q.delete();
      return;
    end
    if (!m_en && !m_inflight && m_cool < 0) begin
      if (m_pend != 0 && !dac_busy) begin
        c = -1;
        for (int k = 0; k < NUM_CH; k++)
          if (c < 0 && m_pend[(m_rr + k) % NUM_CH]) c = (m_rr + k) % NUM_CH;
        m_ch = c; m_val = m_shadow[c]; m_pend[c] = 1'b0;
        m_rr = (c + 1) % NUM_CH; m_en = 1; m_held = 0;
        exp_q.push_back({CH_W'(c), m_val});
      end
    end else if (m_en) begin
      if (dac_busy) begin
        m_en = 0; m_inflight = 1;
      end else begin
        m_held++;
        if (m_held >= TO) begin
          m_en = 0; m_to = 1; m_pend[m_ch] = 1'b1; m_cool = GAP;
          if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
      end
    end else if (m_inflight) begin
      if (!dac_busy) begin m_inflight = 0; m_cool = GAP; end
    end else begin
      if (m_cool > 0) m_cool--;
      else if (!dac_busy) m_cool = -1;
    end
`ifdef DAC_SCHED_REFRESH_EN
    if (upd_we || !m_idle) m_rcnt = 0;
    else if (m_rcnt == REF - 1) begin m_rcnt = 0; m_pend = '1; end
    else m_rcnt++;
`endif
    if (upd_we && upd_ch < NUM_CH) begin
      m_shadow[upd_ch] = upd_value;
      m_pend[upd_ch] = 1'b1;
    end
    m_idle = (!m_en && !m_inflight && m_cool < 0) && (m_pend == 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare, plus an independent gap-length property.
  initial begin
    int cyc_n = 0, last_fall = -1;
    bit prev_busy = 0, prev_en = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc_n++;
      check("cyc_enable", dac_enable, m_en);
      check("cyc_ch", dac_ch, m_ch);
      check("cyc_value", dac_value, m_val);
      check("cyc_pending", pending, m_pend);
      check("cyc_idle", idle, m_idle);
      check("cyc_timeout", timeout_err, m_to);
      if (rst) last_fall = -1;
      else begin
        if (prev_busy && !dac_busy) last_fall = cyc_n;
        if (dac_enable && !prev_en && last_fall >= 0)
          check("gap_len", (cyc_n - last_fall) > GAP, 1);
      end
      prev_busy = dac_busy;
      prev_en = dac_enable;
    end
  end

  // ---------------- DAC engine model ----------------
  bit eng_never = 0;
  int eng_delay = 2, eng_len = 50;
  initial begin
    int eng_wait = 0, eng_left = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        dac_busy = 0; eng_wait = 0; eng_left = 0;
      end else if (eng_left > 0) begin
        eng_left--;
        if (eng_left == 0) dac_busy = 0;
      end else if (dac_enable && !eng_never) begin
        eng_wait++;
        if (eng_wait >= eng_delay) begin
          dac_busy = 1; eng_left = eng_len; eng_wait = 0;
          got_log.push_back({dac_ch, dac_value});
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_unexpected: got ch=%0d val=%0h with nothing expected", dac_ch, dac_value);
          end else begin
            check("sb_xfer", {dac_ch, dac_value}, exp_q.pop_front());
          end
        end
      end else begin
        eng_wait = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wr(input int ch, input int val);
    upd_we = 1; upd_ch = CH_W'(ch); upd_value = VAL_W'(val);
    step();
    upd_we = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (idle !== 1'b1 && n < budget) begin step(); n++; end
    check(name, n < budget, 1);
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    while (dac_busy !== 1'b1 && n < budget) begin step(); n++; end
    check(name, n < budget, 1);
  endtask

  function automatic logic [31:0] xf(input int ch, input int val);
    return {18'd0, CH_W'(ch), VAL_W'(val)};
  endfunction

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, en_cnt, to_cnt;
    repeat (3) step();
    rst = 0;
    check("rst_enable", dac_enable, 0);
    check("rst_pending", pending, 0);
    check("rst_idle", idle, 1);
    check("rst_value", dac_value, 0);

    // single transfer
    base = got_log.size();
    wr(0, 'hABC);
    wait_idle("t1_idle", 500);
    check("t1_count", got_log.size() - base, 1);
    check("t1_xfer", got_log[base], xf(0, 'hABC));
    check("t1_pending", pending, 0);

    // burst of two, then round-robin order from rr=2
    eng_len = 8;
    base = got_log.size();
    wr(0, 'h100); wr(1, 'h200);
    wait_idle("t2_idle", 500);
    check("t2_count", got_log.size() - base, 2);
    check("t2_first", got_log[base], xf(0, 'h100));
    check("t2_second", got_log[base+1], xf(1, 'h200));
    base = got_log.size();
    wr(1, 'h0AA);
    wait_busy("t2_busy", 50);
    wr(0, 'h0B0); wr(2, 'h0C2);
    wait_idle("t2_rr_idle", 500);
    check("t2_rr_count", got_log.size() - base, 3);
    check("t2_rr_a", got_log[base+1], xf(2, 'h0C2));
    check("t2_rr_b", got_log[base+2], xf(0, 'h0B0));

    // coalescing of repeated writes while another channel is in flight
    base = got_log.size();
    wr(0, 'h111);
    wait_busy("t3_busy", 50);
    for (int v = 1; v <= 5; v++) wr(1, v);
    wait_idle("t3_idle", 500);
    check("t3_count", got_log.size() - base, 2);
    check("t3_last", got_log[base+1], xf(1, 'h005));

    // write in the same cycle the channel is latched
    base = got_log.size();
    wr(0, 'h010); wr(0, 'h7FF);
    check("t4_enable", dac_enable, 1);
    check("t4_old_value", dac_value, 'h010);
    check("t4_pending0", pending[0], 1);
    wait_idle("t4_idle", 500);
    check("t4_count", got_log.size() - base, 2);
    check("t4_second", got_log[base+1], xf(0, 'h7FF));

    // accept timeout, then retry
    base = got_log.size();
    eng_never = 1;
    wr(2, 'h3C3);
    en_cnt = 0; to_cnt = 0;
    for (int i = 0; i < TO + 10; i++) begin
      step();
      if (dac_enable) en_cnt++;
      if (timeout_err) begin to_cnt++; break; end
    end
    check("t5_pulses", to_cnt, 1);
    check("t5_hold_cycles", en_cnt, TO);
    check("t5_pending2", pending[2], 1);
    check("t5_enable_low", dac_enable, 0);
    step();
    check("t5_pulse_width", timeout_err, 0);
    eng_never = 0;
    wait_idle("t5_idle", 500);
    check("t5_retry", got_log.size() - base, 1);
    check("t5_retry_xfer", got_log[base], xf(2, 'h3C3));

    // out-of-range channel is ignored
    base = got_log.size();
    wr(3, 'hFFF);
    step(); step();
    check("t6_pending", pending, 0);
    check("t6_idle", idle, 1);
    check("t6_count", got_log.size() - base, 0);

    // reset during WAIT
    eng_len = 20;
    wr(1, 'h456);
    wait_busy("t7_busy", 50);
    step();
    wr(0, 'h333);
    check("t7_pending_pre", pending, 3'b001);
    rst = 1;
    step();
    rst = 0;
    check("t7_enable", dac_enable, 0);
    check("t7_pending", pending, 0);
    check("t7_idle", idle, 1);
    base = got_log.size();
    repeat (5) step();
    check("t7_no_xfer", got_log.size() - base, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 20 == 0) begin
        eng_never = ($urandom_range(0, 9) == 0);
        eng_delay = $urandom_range(1, 3);
        eng_len = $urandom_range(1, 12);
      end
      upd_we = ($urandom_range(0, 9) < 4);
      upd_ch = CH_W'($urandom_range(0, 3));
      upd_value = VAL_W'($urandom);
      step();
    end
    upd_we = 0;
    eng_never = 0;
    wait_idle("rand_drain", 2000);
    check("rand_sb_empty", exp_q.size(), 0);

`ifdef DAC_SCHED_REFRESH_EN
    eng_len = 4; eng_delay = 1;
    base = got_log.size();
    repeat (REF + 60) step();
    check("refresh_count", got_log.size() - base, NUM_CH);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
